// File: rtl/ahb_burst_master_if.sv
// Command, write/read stream and AHB-Lite
// signals of the burst master.
interface ahb_burst_master_if #(
  parameter int LEN_W = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [31:0]      wdata;
  logic             wdata_valid;
  logic             wdata_ready;
  logic [31:0]      rd_data;
  logic             rd_valid;
  logic             done;
  logic             err;
  logic [1:0]       htrans;
  logic             hwrite;
  logic [2:0]       hsize;
  logic [2:0]       hburst;
  logic [31:0]      haddr;
  logic [31:0]      hwdata;
  logic             hready;
  logic [1:0]       hresp;
  logic [31:0]      hrdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wdata, wdata_valid,
    input  hready, hresp, hrdata,
    output cmd_ready, wdata_ready,
    output rd_data, rd_valid, done, err,
    output htrans, hwrite, hsize, hburst,
    output haddr, hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wdata, wdata_valid,
    output hready, hresp, hrdata,
    input  cmd_ready, wdata_ready,
    input  rd_data, rd_valid, done, err,
    input  htrans, hwrite, hsize, hburst,
    input  haddr, hwdata
  );
endinterface

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst initiator: one command
// becomes one word burst, closed by done/err.
module ahb_burst_master #(
  parameter int LEN_W = 5
) (
  input logic                hclk,
  input logic                hresetn,
  ahb_burst_master_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE, S_ADDR, S_LAST, S_ERR
  } state_t;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR   = 3'b001;
  localparam logic [2:0] B_INCR4  = 3'b011;
  localparam logic [2:0] B_INCR8  = 3'b101;
  localparam logic [2:0] B_INCR16 = 3'b111;
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           r_state, w_state_n;
  logic [LEN_W-1:0] r_al, w_al_n;
  logic [LEN_W-1:0] r_dl, w_dl_n;
  logic             r_first, w_first_n;
  logic [31:0]      r_next, w_next_n;
  logic [31:0]      r_wbuf, w_wbuf_n;
  logic [1:0]       r_htrans, w_htrans_n;
  logic             r_hwrite, w_hwrite_n;
  logic [2:0]       r_hburst, w_hburst_n;
  logic [31:0]      r_haddr, w_haddr_n;
  logic [31:0]      r_hwdata, w_hwdata_n;
  logic [31:0]      r_rd_data, w_rd_data_n;
  logic             r_rd_valid, w_rd_valid_n;
  logic             r_done, w_done_n;
  logic             r_err, w_err_n;

  logic [LEN_W-1:0] w_len;
  logic [2:0]       w_burst;
  logic             w_aph, w_dph, w_bad;
  logic             w_cmd_ready, w_wready;

  assign w_len = (bus.cmd_len == '0) ? ONE : bus.cmd_len;
  assign w_aph = r_htrans[1];
  assign w_dph = (r_dl != r_al);
  assign w_bad = (bus.hresp != 2'b00);
  assign w_cmd_ready = (r_state == S_IDLE) && !r_done;

  // Burst type from the beat count
  always_comb begin
    w_burst = B_INCR;
    unique case (1'b1)
      (w_len == LEN_W'(1)):  w_burst = B_SINGLE;
      (w_len == LEN_W'(4)):  w_burst = B_INCR4;
      (w_len == LEN_W'(8)):  w_burst = B_INCR8;
      (w_len == LEN_W'(16)): w_burst = B_INCR16;
      default: ;
    endcase
  end

  // Next state and next registered outputs
  always_comb begin
    w_state_n    = r_state;
    w_al_n       = r_al;
    w_dl_n       = r_dl;
    w_first_n    = r_first;
    w_next_n     = r_next;
    w_wbuf_n     = r_wbuf;
    w_htrans_n   = r_htrans;
    w_hwrite_n   = r_hwrite;
    w_hburst_n   = r_hburst;
    w_haddr_n    = r_haddr;
    w_hwdata_n   = r_hwdata;
    w_rd_data_n  = r_rd_data;
    w_rd_valid_n = 1'b0;
    w_done_n     = 1'b0;
    w_err_n      = 1'b0;
    w_wready     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid && w_cmd_ready) begin
          w_al_n     = w_len;
          w_dl_n     = w_len;
          w_first_n  = 1'b1;
          w_next_n   = bus.cmd_addr & 32'hFFFF_FFFC;
          w_hwrite_n = bus.cmd_write;
          w_hburst_n = w_burst;
          w_state_n  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (w_dph && w_bad) begin
          w_htrans_n = T_IDLE;
          if (bus.hready) begin
            w_done_n  = 1'b1;
            w_err_n   = 1'b1;
            w_state_n = S_IDLE;
          end else begin
            w_state_n = S_ERR;
          end
        end else if (!w_aph || bus.hready) begin
          if (w_dph && bus.hready) begin
            w_dl_n = r_dl - ONE;
            if (!r_hwrite) begin
              w_rd_valid_n = 1'b1;
              w_rd_data_n  = bus.hrdata;
            end
          end
          if (w_aph) begin
            w_al_n = r_al - ONE;
            if (r_hwrite) w_hwdata_n = r_wbuf;
          end
          if (w_al_n == '0) begin
            w_htrans_n = T_IDLE;
            w_state_n  = S_LAST;
          end else if (r_hwrite && !bus.wdata_valid) begin
            w_htrans_n = r_first ? T_IDLE : T_BUSY;
            w_haddr_n  = r_next;
          end else begin
            w_wready  = r_hwrite;
            if (r_hwrite) w_wbuf_n = bus.wdata;
            w_haddr_n = r_next;
            w_next_n  = r_next + 32'd4;
            w_first_n = 1'b0;
            if (r_first) begin
              w_htrans_n = T_NSEQ;
            end else if (r_next[9:0] == 10'd0) begin
              w_htrans_n = T_NSEQ;
              w_hburst_n = B_INCR;
            end else begin
              w_htrans_n = T_SEQ;
            end
          end
        end
      end
      S_LAST: begin
        if (w_bad) begin
          if (bus.hready) begin
            w_done_n  = 1'b1;
            w_err_n   = 1'b1;
            w_state_n = S_IDLE;
          end else begin
            w_state_n = S_ERR;
          end
        end else if (bus.hready) begin
          w_dl_n    = r_dl - ONE;
          w_done_n  = 1'b1;
          w_state_n = S_IDLE;
          if (!r_hwrite) begin
            w_rd_valid_n = 1'b1;
            w_rd_data_n  = bus.hrdata;
          end
        end
      end
      S_ERR: begin
        w_htrans_n = T_IDLE;
        if (bus.hready) begin
          w_done_n  = 1'b1;
          w_err_n   = 1'b1;
          w_state_n = S_IDLE;
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state    <= S_IDLE;
      r_al       <= '0;
      r_dl       <= '0;
      r_first    <= 1'b0;
      r_next     <= '0;
      r_wbuf     <= '0;
      r_htrans   <= T_IDLE;
      r_hwrite   <= 1'b0;
      r_hburst   <= B_SINGLE;
      r_haddr    <= '0;
      r_hwdata   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_al       <= w_al_n;
      r_dl       <= w_dl_n;
      r_first    <= w_first_n;
      r_next     <= w_next_n;
      r_wbuf     <= w_wbuf_n;
      r_htrans   <= w_htrans_n;
      r_hwrite   <= w_hwrite_n;
      r_hburst   <= w_hburst_n;
      r_haddr    <= w_haddr_n;
      r_hwdata   <= w_hwdata_n;
      r_rd_data  <= w_rd_data_n;
      r_rd_valid <= w_rd_valid_n;
      r_done     <= w_done_n;
      r_err      <= w_err_n;
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.wdata_ready = w_wready;
  assign bus.rd_data     = r_rd_data;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.htrans      = r_htrans;
  assign bus.hwrite      = r_hwrite;
  assign bus.hsize       = 3'b010;
  assign bus.hburst      = r_hburst;
  assign bus.haddr       = r_haddr;
  assign bus.hwdata      = r_hwdata;
endmodule
